alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Writeback sequencer directly downstream of the ALU; registers ALU results and drives the register-file write port.
- Single-result ops (ADD/SUB/AND/OR/shifts/rotates) produce one write.
- MUL/DIV produce two writes: the low result to the destination register, then the upper half (product high or remainder) to a fixed HI register.
- ALU exceptions squash the write and are counted for the exception handler.

Parameters:
- REGISTER_DATA_BIT_WIDTH, 16, data width of ALU results and of the register-file write data.
- ALU_CONTROL_WIDTH, 4, width of the function code.
- REG_ADDR_WIDTH, 4, register-file address width.
- HI_ADDR, 4'hF, register receiving the upper half of MUL/DIV results.
- MUL, 4'b0001, multiply function code.
- DIV, 4'b0010, divide function code.
- EXC_CNT_WIDTH, 8, width of the saturating exception counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- In_Valid  in  1  ALU result presented this cycle.
- In_Ready  out  1  block accepts a result this cycle.
- ALU_Ctrl  in  ALU_CONTROL_WIDTH  function code of the presented result.
- R  in  REGISTER_DATA_BIT_WIDTH  ALU primary (low) result.
- S  in  REGISTER_DATA_BIT_WIDTH  ALU upper-half/remainder result.
- ALU_Exception  in  1  ALU flagged overflow or invalid code.
- Dest_Addr  in  REG_ADDR_WIDTH  destination register.
- WB_En  out  1  register-file write enable.
- WB_Addr  out  REG_ADDR_WIDTH  write address.
- WB_Data  out  REGISTER_DATA_BIT_WIDTH  write data.
- Exc_Pulse  out  1  one-cycle pulse per squashed result.
- Exc_Count  out  EXC_CNT_WIDTH  saturating count of exceptions.
- Exc_Clear  in  1  synchronous clear of Exc_Count.

Behaviour:
- Reset (async, any time): state=IDLE; WB_En=0; WB_Addr=0; WB_Data=0; Exc_Pulse=0; Exc_Count=0; held S and address cleared; any pending HI write is dropped.
- Accept = In_Valid & In_Ready, sampled at the rising edge.
- In_Ready is combinational from state: 0 only in WR_DUAL_LO, otherwise 1.
- All outputs are registered.
- States and transitions:
  - IDLE: WB_En=0. On accept, go to the state selected by the accepted op (rule below).
  - WR_SINGLE: WB_En=1, WB_Addr=Dest_Addr, WB_Data=R of the op accepted last cycle. On accept, go to the next op's state; otherwise IDLE.
  - WR_DUAL_LO: WB_En=1, WB_Addr=Dest_Addr, WB_Data=R. S and the op are held internally. Unconditionally go to WR_DUAL_HI (no accept possible).
  - WR_DUAL_HI: WB_En=1, WB_Addr=HI_ADDR, WB_Data=held S. On accept, go to the next op's state; otherwise IDLE.
- Op-state selection on accept:
  - ALU_Exception=1: state IDLE, no write, Exc_Pulse=1 next cycle.
  - ALU_Ctrl==MUL or DIV: WR_DUAL_LO.
  - Otherwise: WR_SINGLE.
- Latency: accept at edge N gives the first write visible N+1 and, for MUL/DIV, the HI write N+2.
- Throughput: one single op per cycle; one MUL/DIV per two cycles; no bubbles between back-to-back ops.
- Exception with ALU_Ctrl==MUL/DIV: squashed entirely, neither write occurs.
- Dest_Addr==HI_ADDR on MUL/DIV: both writes go to HI_ADDR in order; the second write (S) is final.
- Exc_Count:
  - Increments by 1 on each accepted exception; saturates at all-ones, no wrap.
  - Exc_Clear alone sets it to 0.
  - Exc_Clear in the same cycle as an accepted exception sets it to 1.
- In_Valid=1 while In_Ready=0: input ignored; the upstream holds it until the next cycle.
- WB_Addr/WB_Data hold their last values when WB_En=0. Only WB_En is significant to the register file.

Test Plan:
- Reset then ADD (Ctrl=4'b1111), R=16'h0005, Dest=3 accepted at edge 1 -> edge 2: WB_En=1, WB_Addr=3, WB_Data=16'h0005; edge 3: WB_En=0.
- MUL, R=16'h2000, S=16'h0001, Dest=2 -> edge N+1 writes (2, 16'h2000); In_Ready=0 in that cycle; edge N+2 writes (15, 16'h0001).
- Back-to-back: DIV (R=7, S=3, Dest=4), then ADD held valid (R=9, Dest=5) -> writes (4,7), (15,3), (5,9) on three consecutive cycles; ADD accepted during WR_DUAL_HI.
- ADD with ALU_Exception=1, Dest=6 -> no WB_En, Exc_Pulse=1 for exactly one cycle, Exc_Count 0->1. Repeat 300 times -> Exc_Count=8'hFF. Then Exc_Clear plus an exception in the same cycle -> Exc_Count=1.
- MUL with Dest=15, R=16'hAAAA, S=16'h5555 -> writes (15,AAAA) then (15,5555).
- Assert rst asynchronously mid-clock while in WR_DUAL_LO -> outputs 0 immediately, no HI write after release, In_Ready=1.

Source files
------------

// File: rtl/alu_writeback.sv
// alu_writeback
//   Writeback sequencer placed directly after the ALU. It registers each
//   accepted ALU result and drives the register-file write port. Single-result
//   ops produce one write. MUL/DIV produce two writes on consecutive cycles:
//   R to the destination register, then S (product high / remainder) to
//   HI_ADDR. Results flagged with ALU_Exception are squashed and counted.
//
//   State table
//     IDLE       | no write this cycle
//     WR_SINGLE  | writing R of a single-result op to its destination
//     WR_DUAL_LO | writing R of MUL/DIV to its destination; input stalled
//     WR_DUAL_HI | writing held S of MUL/DIV to HI_ADDR
//
//   Ports
//     clk, rst              clock (rising edge), async active-high reset
//     In_Valid / In_Ready   result handshake (accept = In_Valid & In_Ready)
//     ALU_Ctrl, R, S        function code, low result, upper/remainder result
//     ALU_Exception         squash this result and count it
//     Dest_Addr             destination register of the result
//     WB_En/WB_Addr/WB_Data register-file write port (registered)
//     Exc_Pulse             one-cycle pulse per squashed result (registered)
//     Exc_Count             saturating exception count (registered)
//     Exc_Clear             synchronous clear of Exc_Count
module alu_writeback #(
  parameter int REGISTER_DATA_BIT_WIDTH = 16,
  parameter int ALU_CONTROL_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH          = 4,
  parameter logic [REG_ADDR_WIDTH-1:0]    HI_ADDR = 4'hF,
  parameter logic [ALU_CONTROL_WIDTH-1:0] MUL     = 4'b0001,
  parameter logic [ALU_CONTROL_WIDTH-1:0] DIV     = 4'b0010,
  parameter int EXC_CNT_WIDTH           = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               In_Valid,
  output logic                               In_Ready,
  input  logic [ALU_CONTROL_WIDTH-1:0]       ALU_Ctrl,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] R,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] S,
  input  logic                               ALU_Exception,
  input  logic [REG_ADDR_WIDTH-1:0]          Dest_Addr,
  output logic                               WB_En,
  output logic [REG_ADDR_WIDTH-1:0]          WB_Addr,
  output logic [REGISTER_DATA_BIT_WIDTH-1:0] WB_Data,
  output logic                               Exc_Pulse,
  output logic [EXC_CNT_WIDTH-1:0]           Exc_Count,
  input  logic                               Exc_Clear
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_SINGLE  = 2'd1,
    WR_DUAL_LO = 2'd2,
    WR_DUAL_HI = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                               w_accept;
  logic                               w_exc_acc;
  logic                               w_is_dual;
  logic                               w_cnt_sat;

  logic                               r_wb_en;
  logic [REG_ADDR_WIDTH-1:0]          r_wb_addr;
  logic [REGISTER_DATA_BIT_WIDTH-1:0] r_wb_data;
  logic [REGISTER_DATA_BIT_WIDTH-1:0] r_s_hold;
  logic                               r_exc_pulse;
  logic [EXC_CNT_WIDTH-1:0]           r_exc_count;

  assign In_Ready  = (r_state != WR_DUAL_LO);
  assign w_accept  = In_Valid & In_Ready;
  assign w_exc_acc = w_accept & ALU_Exception;
  assign w_is_dual = (ALU_Ctrl == MUL) || (ALU_Ctrl == DIV);
  assign w_cnt_sat = (r_exc_count == {EXC_CNT_WIDTH{1'b1}});

  always_comb begin
    w_next = IDLE;
    case (r_state)
      WR_DUAL_LO: w_next = WR_DUAL_HI;
      default: begin
        if (w_accept) begin
          if (ALU_Exception) w_next = IDLE;
          else if (w_is_dual) w_next = WR_DUAL_LO;
          else w_next = WR_SINGLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Write port is registered alongside the state: the value loaded here is
  // what the state entered at this edge writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_s_hold  <= '0;
    end else begin
      r_wb_en <= (w_next != IDLE);
      if (r_state == WR_DUAL_LO) begin
        r_wb_addr <= HI_ADDR;
        r_wb_data <= r_s_hold;
      end else if (w_accept && !ALU_Exception) begin
        r_wb_addr <= Dest_Addr;
        r_wb_data <= R;
        r_s_hold  <= S;
      end
    end
  end

  // Clear wins over the old value but still counts a coincident exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc_pulse <= 1'b0;
      r_exc_count <= '0;
    end else begin
      r_exc_pulse <= w_exc_acc;
      if (Exc_Clear)
        r_exc_count <= w_exc_acc ? EXC_CNT_WIDTH'(1) : '0;
      else if (w_exc_acc && !w_cnt_sat)
        r_exc_count <= r_exc_count + 1'b1;
    end
  end

  assign WB_En     = r_wb_en;
  assign WB_Addr   = r_wb_addr;
  assign WB_Data   = r_wb_data;
  assign Exc_Pulse = r_exc_pulse;
  assign Exc_Count = r_exc_count;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [3:0]  ALU_Ctrl;
  logic [15:0] R;
  logic [15:0] S;
  logic        ALU_Exception;
  logic [3:0]  Dest_Addr;
  logic        WB_En;
  logic [3:0]  WB_Addr;
  logic [15:0] WB_Data;
  logic        Exc_Pulse;
  logic [7:0]  Exc_Count;
  logic        Exc_Clear;

  int errors = 0;
  int checks = 0;

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_Ctrl(ALU_Ctrl), .R(R), .S(S),
    .ALU_Exception(ALU_Exception), .Dest_Addr(Dest_Addr),
    .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Exc_Pulse(Exc_Pulse), .Exc_Count(Exc_Count), .Exc_Clear(Exc_Clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  ctrl;
    logic [15:0] r;
    logic [15:0] s;
    logic        exc;
    logic [3:0]  dest;
    logic        clr;
    logic        e_rdy;
    logic        e_en;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_pulse;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] C_ADD = 4'b1111;
  localparam logic [3:0] C_MUL = 4'b0001;
  localparam logic [3:0] C_DIV = 4'b0010;

  function automatic vec_t mk(logic vld, logic [3:0] ctrl, logic [15:0] r, logic [15:0] s,
                              logic exc, logic [3:0] dest, logic clr, logic e_rdy,
                              logic e_en, logic [3:0] e_addr, logic [15:0] e_data,
                              logic e_pulse, logic [7:0] e_cnt);
    vec_t v;
    v.vld = vld; v.ctrl = ctrl; v.r = r; v.s = s; v.exc = exc; v.dest = dest; v.clr = clr;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_pulse = e_pulse; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [3:0] addr,
                         input logic [15:0] data, input logic pulse, input logic [7:0] cnt);
    chk({tag, ".WB_En"}, 32'(WB_En), 32'(en));
    chk({tag, ".WB_Addr"}, 32'(WB_Addr), 32'(addr));
    chk({tag, ".WB_Data"}, 32'(WB_Data), 32'(data));
    chk({tag, ".Exc_Pulse"}, 32'(Exc_Pulse), 32'(pulse));
    chk({tag, ".Exc_Count"}, 32'(Exc_Count), 32'(cnt));
  endtask

  initial begin
    //        vld ctrl   r        s        exc dest clr | rdy en addr data     pls cnt
    vecs.push_back(mk(1, C_ADD, 16'h0005, 16'h0000, 0, 4'd3, 0, 1, 1, 4'd3,  16'h0005, 0, 8'd0));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 1, 0, 4'd3,  16'h0005, 0, 8'd0));
    vecs.push_back(mk(1, C_MUL, 16'h2000, 16'h0001, 0, 4'd2, 0, 1, 1, 4'd2,  16'h2000, 0, 8'd0));
    // ADD presented while stalled: ignored, re-presented next cycle
    vecs.push_back(mk(1, C_ADD, 16'h1234, 16'h0000, 0, 4'd7, 0, 0, 1, 4'd15, 16'h0001, 0, 8'd0));
    vecs.push_back(mk(1, C_ADD, 16'h1234, 16'h0000, 0, 4'd7, 0, 1, 1, 4'd7,  16'h1234, 0, 8'd0));
    vecs.push_back(mk(1, C_DIV, 16'h0007, 16'h0003, 0, 4'd4, 0, 1, 1, 4'd4,  16'h0007, 0, 8'd0));
    vecs.push_back(mk(1, C_ADD, 16'h0009, 16'h0000, 0, 4'd5, 0, 0, 1, 4'd15, 16'h0003, 0, 8'd0));
    vecs.push_back(mk(1, C_ADD, 16'h0009, 16'h0000, 0, 4'd5, 0, 1, 1, 4'd5,  16'h0009, 0, 8'd0));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 1, 0, 4'd5,  16'h0009, 0, 8'd0));
    vecs.push_back(mk(1, C_ADD, 16'hFFFF, 16'h0000, 1, 4'd6, 0, 1, 0, 4'd5,  16'h0009, 1, 8'd1));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 1, 0, 4'd5,  16'h0009, 0, 8'd1));
    vecs.push_back(mk(1, C_MUL, 16'h0001, 16'h0002, 1, 4'd8, 0, 1, 0, 4'd5,  16'h0009, 1, 8'd2));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 1, 0, 4'd5,  16'h0009, 0, 8'd2));
    vecs.push_back(mk(1, C_MUL, 16'hAAAA, 16'h5555, 0, 4'd15, 0, 1, 1, 4'd15, 16'hAAAA, 0, 8'd2));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd15, 16'h5555, 0, 8'd2));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 0, 1, 0, 4'd15, 16'h5555, 0, 8'd2));
    vecs.push_back(mk(0, C_ADD, 16'h0000, 16'h0000, 0, 4'd0, 1, 1, 0, 4'd15, 16'h5555, 0, 8'd0));

    rst = 1'b1; In_Valid = 0; ALU_Ctrl = 0; R = 0; S = 0;
    ALU_Exception = 0; Dest_Addr = 0; Exc_Clear = 0;
    #12;
    chk_out("reset", 0, 4'd0, 16'h0000, 0, 8'd0);
    chk("reset.In_Ready", 32'(In_Ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      In_Valid = vecs[i].vld; ALU_Ctrl = vecs[i].ctrl; R = vecs[i].r; S = vecs[i].s;
      ALU_Exception = vecs[i].exc; Dest_Addr = vecs[i].dest; Exc_Clear = vecs[i].clr;
      chk($sformatf("vec%0d.In_Ready", i), 32'(In_Ready), 32'(vecs[i].e_rdy));
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data,
              vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // 300 back-to-back exceptions: counter climbs then saturates at FF
    In_Valid = 1; ALU_Ctrl = C_ADD; ALU_Exception = 1; Dest_Addr = 4'd6; R = 16'h0BAD; Exc_Clear = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) chk("sat.cnt254", 32'(Exc_Count), 32'd254);
      if (i == 254) chk("sat.cnt255", 32'(Exc_Count), 32'd255);
    end
    chk_out("sat.after300", 0, 4'd15, 16'h5555, 1, 8'hFF);

    Exc_Clear = 1;
    step();
    chk("clr_exc.cnt", 32'(Exc_Count), 32'd1);
    chk("clr_exc.pulse", 32'(Exc_Pulse), 32'd1);
    Exc_Clear = 0; In_Valid = 0; ALU_Exception = 0;
    step();
    chk("post_clr.pulse", 32'(Exc_Pulse), 32'd0);
    chk("post_clr.cnt", 32'(Exc_Count), 32'd1);

    // Async reset while in WR_DUAL_LO drops the pending HI write
    In_Valid = 1; ALU_Ctrl = C_MUL; R = 16'h1111; S = 16'h2222; Dest_Addr = 4'd9;
    step();
    chk("rst_mid.lo_en", 32'(WB_En), 32'd1);
    chk("rst_mid.lo_rdy", 32'(In_Ready), 32'd0);
    In_Valid = 0;
    #2 rst = 1'b1;
    #1;
    chk_out("rst_mid.async", 0, 4'd0, 16'h0000, 0, 8'd0);
    chk("rst_mid.In_Ready", 32'(In_Ready), 32'd1);
    #1 rst = 1'b0;
    step();
    chk_out("rst_mid.after", 0, 4'd0, 16'h0000, 0, 8'd0);
    step();
    chk("rst_mid.after2_en", 32'(WB_En), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
